logic_op_sequencer: RTL and testbench

- Command-driven controller for the calculator's bitwise logic unit (AND, NAND, NOR, NOT, OR, XNOR, XOR).
- Queues opcode/operand commands from the middleware bridge and applies each one to an internal accumulator.
- Returns one result per command through a valid/ready handshake.
- Sits between the host command interface and the logic datapath, serialising access to that datapath.

---
 rtl/logic_seq_pkg.sv | 24 ++
 rtl/logic_cmd_fifo.sv | 53 +++++
 rtl/logic_op_sequencer.sv | 118 +++++++++++
 tb/tb_logic_op_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_seq_pkg.sv
// Shared opcodes, FSM encoding and default sizing for the logic op sequencer.
package logic_seq_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 32;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
    localparam int unsigned OP_W               = 4;

    localparam logic [OP_W-1:0] OP_LOAD  = 4'd0;
    localparam logic [OP_W-1:0] OP_AND   = 4'd1;
    localparam logic [OP_W-1:0] OP_NAND  = 4'd2;
    localparam logic [OP_W-1:0] OP_NOR   = 4'd3;
    localparam logic [OP_W-1:0] OP_NOT   = 4'd4;
    localparam logic [OP_W-1:0] OP_OR    = 4'd5;
    localparam logic [OP_W-1:0] OP_XNOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd7;
    localparam logic [OP_W-1:0] OP_CLEAR = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_cmd_fifo.sv
// Power-of-two command queue with registered pointers and a show-ahead head word.
module logic_cmd_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/logic_op_sequencer.sv
// Queues logic-unit commands, applies them in order to an accumulator, returns one result each.
module logic_op_sequencer
    import logic_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic [WIDTH-1:0] acc_out,
    output logic             busy
);

    localparam int unsigned CMD_W = WIDTH + OP_W;

    state_t           state;
    state_t           state_d;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_dout;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             illegal;

    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign acc_out   = acc;

    logic_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (pop),
        .din   ({cmd_op, cmd_operand}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bitwise evaluation of the captured command against the accumulator.
    always_comb begin
        acc_next = acc;
        illegal  = 1'b0;
        case (op_q)
            OP_LOAD:  acc_next = operand_q;
            OP_AND:   acc_next = acc & operand_q;
            OP_NAND:  acc_next = ~(acc & operand_q);
            OP_NOR:   acc_next = ~(acc | operand_q);
            OP_NOT:   acc_next = ~acc;
            OP_OR:    acc_next = acc | operand_q;
            OP_XNOR:  acc_next = ~(acc ^ operand_q);
            OP_XOR:   acc_next = acc ^ operand_q;
            OP_CLEAR: acc_next = '0;
            default:  illegal  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result registers stay frozen through RESP until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            operand_q <= '0;
            acc       <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (pop) begin
                op_q      <= fifo_dout[CMD_W-1:WIDTH];
                operand_q <= fifo_dout[WIDTH-1:0];
            end
            if (state == EXEC) begin
                acc       <= acc_next;
                res_data  <= acc_next;
                res_err   <= illegal;
                res_valid <= 1'b1;
            end else if ((state == RESP) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer with hand-computed results.
module tb_logic_op_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_operand;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
    logic [31:0] acc_out;
    logic        busy;

    int vectors;
    int miscompares;

    logic_op_sequencer #(.WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err),
        .acc_out     (acc_out),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one command, waits for its result and consumes it; lat=99 on timeout.
    task automatic issue(input logic [3:0] op, input logic [31:0] opnd,
                         output logic [31:0] data, output logic err, output int lat);
        int waitc;
        lat  = 99;
        data = '0;
        err  = 1'b0;
        cmd_op      = op;
        cmd_operand = opnd;
        cmd_valid   = 1'b1;
        waitc = 0;
        while (!cmd_ready && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                lat  = c;
                data = res_data;
                err  = res_err;
                break;
            end
        end
        if (lat != 99) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        vectors++; if (res_data !== 32'h0) begin miscompares++; $display("FAIL reset_res_data got %h want 0", res_data); end
        vectors++; if (res_err !== 1'b0) begin miscompares++; $display("FAIL reset_res_err got %b want 0", res_err); end
        vectors++; if (acc_out !== 32'h0) begin miscompares++; $display("FAIL reset_acc_out got %h want 0", acc_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic        e;
        int          l;
        issue(4'd0, 32'hF0F0_1234, d, e, l);
        vectors++; if (d !== 32'hF0F01234) begin miscompares++; $display("FAIL basic_load_data got %h want F0F01234", d); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL basic_load_err got %b want 0", e); end
        vectors++; if (l !== 2) begin miscompares++; $display("FAIL basic_load_latency got %0d want 2", l); end
        issue(4'd1, 32'h0FF0_FFFF, d, e, l);
        vectors++; if (d !== 32'h00F01234) begin miscompares++; $display("FAIL basic_and_data got %h want 00F01234", d); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL basic_and_err got %b want 0", e); end
        vectors++; if (l !== 2) begin miscompares++; $display("FAIL basic_and_latency got %0d want 2", l); end
        vectors++; if (acc_out !== 32'h00F01234) begin miscompares++; $display("FAIL basic_acc_out got %h want 00F01234", acc_out); end
    endtask

    task automatic test_chain();
        logic [3:0]  ops  [5] = '{4'd0, 4'd7, 4'd6, 4'd2, 4'd3};
        logic [31:0] opnd [5] = '{32'h1234_5678, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] exp  [5] = '{32'h12345678, 32'hEDCB5678, 32'h12345678, 32'hEDCBA987, 32'h12345678};
        logic [31:0] d;
        logic        e;
        int          l;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], opnd[i], d, e, l);
            vectors++; if (d !== exp[i]) begin miscompares++; $display("FAIL chain_%0d_data got %h want %h", i, d, exp[i]); end
            vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL chain_%0d_err got %b want 0", i, e); end
        end
    endtask

    task automatic test_not_clear();
        logic [31:0] d;
        logic        e;
        int          l;
        issue(4'd0, 32'h0000_FFFF, d, e, l);
        vectors++; if (d !== 32'h0000FFFF) begin miscompares++; $display("FAIL notclr_load got %h want 0000FFFF", d); end
        issue(4'd4, 32'hDEAD_BEEF, d, e, l);
        vectors++; if (d !== 32'hFFFF0000) begin miscompares++; $display("FAIL notclr_not got %h want FFFF0000", d); end
        issue(4'd8, 32'h1234_5678, d, e, l);
        vectors++; if (d !== 32'h00000000) begin miscompares++; $display("FAIL notclr_clear got %h want 00000000", d); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL notclr_clear_err got %b want 0", e); end
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        logic        e;
        int          l;
        issue(4'd0, 32'hAAAA_5555, d, e, l);
        issue(4'hC, 32'hFFFF_FFFF, d, e, l);
        vectors++; if (d !== 32'hAAAA5555) begin miscompares++; $display("FAIL illegal_data got %h want AAAA5555", d); end
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL illegal_err got %b want 1", e); end
        vectors++; if (acc_out !== 32'hAAAA5555) begin miscompares++; $display("FAIL illegal_acc got %h want AAAA5555", acc_out); end
        issue(4'd5, 32'h0000_0000, d, e, l);
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL illegal_next_err got %b want 0", e); end
        vectors++; if (d !== 32'hAAAA5555) begin miscompares++; $display("FAIL illegal_next_data got %h want AAAA5555", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] opnd [6] = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd32};
        logic [31:0] exp  [5] = '{32'd1, 32'd3, 32'd7, 32'd15, 32'd31};
        logic [31:0] got  [5];
        int          accepted;
        logic        sixth_ready;
        int          n;
        res_ready   = 1'b0;
        accepted    = 0;
        sixth_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_op      = (i == 0) ? 4'd0 : 4'd5;
            cmd_operand = opnd[i];
            cmd_valid   = 1'b1;
            if (cmd_ready) accepted++;
            if (i == 5) sixth_ready = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        vectors++; if (accepted !== 5) begin miscompares++; $display("FAIL bp_accepted got %0d want 5", accepted); end
        vectors++; if (sixth_ready !== 1'b0) begin miscompares++; $display("FAIL bp_sixth_ready got %b want 0", sixth_ready); end
        repeat (3) begin @(posedge clk); #1; end
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL bp_stall_valid got %b want 1", res_valid); end
        vectors++; if (res_data !== 32'd1) begin miscompares++; $display("FAIL bp_stall_data got %h want 1", res_data); end
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall_ready got %b want 0", cmd_ready); end
        res_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            if (res_valid) begin
                got[n] = res_data;
                n++;
            end
            @(posedge clk); #1;
        end
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL bp_result_count got %0d want 5", n); end
        for (int i = 0; i < n; i++) begin
            vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL bp_result_%0d got %0d want %0d", i, got[i], exp[i]); end
        end
        repeat (2) begin @(posedge clk); #1; end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_busy_after got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int seen;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_op      = (i == 0) ? 4'd0 : 4'd5;
            cmd_operand = 32'h0000_0005 << i;
            cmd_valid   = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_in_resp got %b want 1", res_valid); end
        rst = 1'b1;
        #1;
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_res_valid got %b want 0", res_valid); end
        vectors++; if (acc_out !== 32'h0) begin miscompares++; $display("FAIL rmid_acc_out got %h want 0", acc_out); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_cmd_ready got %b want 1", cmd_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b want 0", busy); end
        vectors++; if (res_data !== 32'h0) begin miscompares++; $display("FAIL rmid_res_data got %h want 0", res_data); end
        @(negedge clk);
        rst       = 1'b0;
        res_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rmid_results_after got %0d want 0", seen); end
        vectors++; if (acc_out !== 32'h0) begin miscompares++; $display("FAIL rmid_acc_after got %h want 0", acc_out); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 4'd0;
        cmd_operand = 32'h0;
        res_ready   = 1'b1;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_chain();
        test_not_clear();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
